// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and the per-axis raster region encoding.
// Shared by the timing generator and anything that needs to decode scan positions.
package vga_timing_pkg;

  localparam int unsigned HActive = 640;
  localparam int unsigned HFp     = 16;
  localparam int unsigned HSync   = 96;
  localparam int unsigned HBp     = 48;
  localparam int unsigned VActive = 480;
  localparam int unsigned VFp     = 10;
  localparam int unsigned VSync   = 2;
  localparam int unsigned VBp     = 33;

  localparam int unsigned HTotal = HActive + HFp + HSync + HBp;
  localparam int unsigned VTotal = VActive + VFp + VSync + VBp;

  typedef enum logic [1:0] {
    RegAct  = 2'd0,
    RegFp   = 2'd1,
    RegSync = 2'd2,
    RegBp   = 2'd3
  } region_e;

  // Regions follow each other ACT -> FP -> SYNC -> BP along one axis.
  function automatic region_e region_of(input int unsigned pos, input int unsigned act,
                                        input int unsigned fp, input int unsigned sync);
    if (pos < act) return RegAct;
    if (pos < act + fp) return RegFp;
    if (pos < act + fp + sync) return RegSync;
    return RegBp;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Tick-enabled shift register that delays the sync/valid flags by DEPTH pixels.
// Synchronous reset loads every stage with the supplied idle value.
module sync_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH*WIDTH-1:0] r_sr;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_sr <= i_rst_val;
      end else if (i_tick) begin
        r_sr <= i_data;
      end
    end
  end else begin : g_multi
    // Newest stage sits in the low bits; the oldest leaves through the top.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_sr <= {DEPTH{i_rst_val}};
      end else if (i_tick) begin
        r_sr <= {r_sr[(DEPTH-1)*WIDTH-1:0], i_data};
      end
    end
  end

  assign o_data = r_sr[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v scan counters, frame counter, and
// sync/valid flags delayed to match the pixel path's block-memory read latency.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = HActive,
  parameter int unsigned H_FP     = HFp,
  parameter int unsigned H_SYNC   = HSync,
  parameter int unsigned H_BP     = HBp,
  parameter int unsigned V_ACTIVE = VActive,
  parameter int unsigned V_FP     = VFp,
  parameter int unsigned V_SYNC   = VSync,
  parameter int unsigned V_BP     = VBp,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  output logic       o_pix_tick,
  output logic [9:0] o_h_cnt,
  output logic [9:0] o_v_cnt,
  output logic       o_valid,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_line_start,
  output logic       o_frame_start,
  output logic [7:0] o_frame_cnt
);

  localparam int unsigned HTot  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned Depth = (PIPE_DLY == 0) ? 1 : PIPE_DLY;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HLast   = 10'(HTot - 1);
  localparam logic [9:0]      VLast   = 10'(VTot - 1);

  logic [DivW-1:0] r_div_cnt;
  logic [9:0]      r_h_cnt;
  logic [9:0]      r_v_cnt;
  logic [7:0]      r_frame_cnt;
  logic            r_pix_tick;
  logic            r_line_start;
  logic            r_frame_start;

  logic            w_adv;
  logic            w_h_wrap;
  logic            w_v_wrap;
  logic [9:0]      w_h_nxt;
  logic [9:0]      w_v_nxt;
  logic [2:0]      w_flags_in;
  logic [2:0]      w_flags_rst;
  logic [2:0]      w_flags_dly;

  // Flags packed as {valid, hsync, vsync} for one scan position.
  function automatic logic [2:0] raw_flags(input logic [9:0] h, input logic [9:0] v);
    region_e h_reg;
    region_e v_reg;
    h_reg = region_of(32'(h), H_ACTIVE, H_FP, H_SYNC);
    v_reg = region_of(32'(v), V_ACTIVE, V_FP, V_SYNC);
    return {(h_reg == RegAct) && (v_reg == RegAct),
            (h_reg == RegSync) ? SYNC_POL : ~SYNC_POL,
            (v_reg == RegSync) ? SYNC_POL : ~SYNC_POL};
  endfunction

  assign w_adv    = i_en && (r_div_cnt == DivLast);
  assign w_h_wrap = (r_h_cnt == HLast);
  assign w_v_wrap = w_h_wrap && (r_v_cnt == VLast);

  always_comb begin
    w_h_nxt = r_h_cnt;
    w_v_nxt = r_v_cnt;
    if (w_adv) begin
      w_h_nxt = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
      if (w_h_wrap) begin
        w_v_nxt = w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div_cnt     <= '0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_frame_cnt   <= '0;
      r_pix_tick    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_tick    <= w_adv;
      r_line_start  <= w_adv && w_h_wrap;
      r_frame_start <= w_adv && w_v_wrap;
      if (i_en) begin
        r_div_cnt <= (r_div_cnt == DivLast) ? '0 : r_div_cnt + DivW'(1);
      end
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      if (w_adv && w_v_wrap) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // Zero delay registers the flags of the position being entered so they line up
  // with h_cnt/v_cnt; otherwise the current position enters the delay chain.
  assign w_flags_in  = (PIPE_DLY == 0) ? raw_flags(w_h_nxt, w_v_nxt)
                                       : raw_flags(r_h_cnt, r_v_cnt);
  assign w_flags_rst = {1'b0, ~SYNC_POL, ~SYNC_POL};

  sync_delay_line #(
    .DEPTH(Depth),
    .WIDTH(3)
  ) u_sync_delay_line (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_tick   (w_adv),
    .i_rst_val(w_flags_rst),
    .i_data   (w_flags_in),
    .o_data   (w_flags_dly)
  );

  assign o_pix_tick    = r_pix_tick;
  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_valid       = w_flags_dly[2];
  assign o_hsync       = w_flags_dly[1];
  assign o_vsync       = w_flags_dly[0];
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;

endmodule
